map_access_scheduler: RTL and testbench



---
 rtl/map_access_scheduler.sv | 115 +++++++++++
 tb/tb_map_access_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/map_access_scheduler.sv
// Single-port map RAM scheduler: display > robot side (write/sensor round-robin), fixed 2-cycle read latency.
// Optional starvation override of display enabled by defining MAP_ARB_STARVE_GUARD_EN.
module map_access_scheduler #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clock_50,
  input  logic              reset_flag,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              disp_miss,
  input  logic              sens_req,
  input  logic [ADDR_W-1:0] sens_addr,
  output logic              sens_gnt,
  output logic [DATA_W-1:0] sens_data,
  output logic              sens_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int STAGES = 2;

  typedef struct packed {
    logic disp;
    logic sens;
  } rd_tag_t;

  if (STARVE_MAX < 1) begin : g_cfg_check
    $error("STARVE_MAX must be at least 1");
  end

  rd_tag_t               rd_s0;
  rd_tag_t [STAGES:1]    vld_pipe;
  logic                  rr_wr;        // 1: write wins a robot-side tie
  logic                  starve_ovr;
  logic                  robot_req;
  logic                  pick_wr;

`ifdef MAP_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  logic [CNT_W-1:0] starve_cnt;

  assign starve_ovr = (starve_cnt >= STARVE_LIM);

  always_ff @(posedge clock_50 or posedge reset_flag) begin
    if (reset_flag)               starve_cnt <= '0;
    else if (wr_gnt || sens_gnt)  starve_cnt <= '0;
    else if (robot_req && !starve_ovr) starve_cnt <= starve_cnt + 1'b1;
  end
`else
  assign starve_ovr = 1'b0;
`endif

  assign robot_req = wr_req | sens_req;
  assign pick_wr   = wr_req & (~sens_req | rr_wr);

  always_comb begin
    disp_gnt = 1'b0;
    sens_gnt = 1'b0;
    wr_gnt   = 1'b0;
    if (!reset_flag) begin
      if (disp_req && !starve_ovr) begin
        disp_gnt = 1'b1;
      end else if (robot_req) begin
        wr_gnt   = pick_wr;
        sens_gnt = ~pick_wr;
      end
    end
  end

  assign rd_s0 = '{disp: disp_gnt, sens: sens_gnt};

  always_ff @(posedge clock_50 or posedge reset_flag) begin
    if (reset_flag) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rr_wr     <= 1'b1;
      vld_pipe  <= '0;
      disp_miss <= 1'b0;
    end else begin
      mem_en    <= disp_gnt | sens_gnt | wr_gnt;
      mem_we    <= wr_gnt;
      if (disp_gnt)      mem_addr <= disp_addr;
      else if (wr_gnt)   mem_addr <= wr_addr;
      else if (sens_gnt) mem_addr <= sens_addr;
      if (wr_gnt) mem_wdata <= wr_data;
      if (wr_gnt || sens_gnt) rr_wr <= sens_gnt;
      vld_pipe  <= {vld_pipe[STAGES-1:1], rd_s0};
      disp_miss <= disp_req & ~disp_gnt;
    end
  end

  // RAM output is live during the last pipeline stage, so results are steered combinationally
  assign disp_valid = vld_pipe[STAGES].disp;
  assign sens_valid = vld_pipe[STAGES].sens;
  assign disp_data  = disp_valid ? mem_rdata : '0;
  assign sens_data  = sens_valid ? mem_rdata : '0;
  assign busy       = disp_req | sens_req | wr_req | (|vld_pipe);

endmodule

// File: tb/tb_map_access_scheduler.sv
// Bench for map_access_scheduler: write-first RAM model, per-cycle reference model and directed checks.
module tb_map_access_scheduler;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 4;
  localparam int SMAX   = 8;
`ifdef MAP_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  localparam int W_NONE = 0, W_DISP = 1, W_SENS = 2, W_WR = 3;

  logic              clock_50 = 1'b0;
  logic              reset_flag = 1'b0;
  logic              disp_req = 0, sens_req = 0, wr_req = 0;
  logic [ADDR_W-1:0] disp_addr = 0, sens_addr = 0, wr_addr = 0;
  logic [DATA_W-1:0] wr_data = 0;
  logic              disp_gnt, disp_valid, disp_miss, sens_gnt, sens_valid, wr_gnt;
  logic [DATA_W-1:0] disp_data, sens_data, mem_wdata;
  logic              mem_en, mem_we, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = 0;

  map_access_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(SMAX)) dut (
    .clock_50(clock_50), .reset_flag(reset_flag),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt), .disp_data(disp_data),
    .disp_valid(disp_valid), .disp_miss(disp_miss),
    .sens_req(sens_req), .sens_addr(sens_addr), .sens_gnt(sens_gnt), .sens_data(sens_data),
    .sens_valid(sens_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #10 clock_50 = ~clock_50;

  // write-first synchronous RAM
  logic [DATA_W-1:0] ram [512];
  always @(posedge clock_50) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        mem_rdata     <= mem_wdata;
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  int n_chk = 0, n_fail = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; bit disp; logic [DATA_W-1:0] data; } rd_t;
  rd_t rq[$];
  logic [DATA_W-1:0] shadow [512];
  int   turn = W_WR, starve = 0;
  bit   e_en = 0, e_we = 0, e_miss = 0;
  logic [ADDR_W-1:0] e_addr = 0;
  logic [DATA_W-1:0] e_wdata = 0;
  bit   pw_v = 0;
  logic [ADDR_W-1:0] pw_a = 0;
  logic [DATA_W-1:0] pw_d = 0;

  always @(negedge clock_50) begin
    int win;
    bit dv, sv, e_busy;
    logic [DATA_W-1:0] dd, sd;
    cyc++;
    if (reset_flag) begin
      chk("rst_gnt", 32'({disp_gnt, sens_gnt, wr_gnt}), 32'd0);
      chk("rst_mem", 32'({mem_en, mem_we, mem_addr, mem_wdata}), 32'd0);
      chk("rst_out", 32'({disp_valid, sens_valid, disp_miss, disp_data, sens_data}), 32'd0);
      rq.delete();
      turn = W_WR; starve = 0; pw_v = 0;
      e_en = 0; e_we = 0; e_miss = 0;
    end else begin
      chk("mem_en", 32'(mem_en), 32'(e_en));
      if (e_en) begin
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        if (e_we) chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      end
      chk("disp_miss", 32'(disp_miss), 32'(e_miss));
      e_busy = disp_req || sens_req || wr_req || (rq.size() != 0);
      dv = 0; sv = 0; dd = 0; sd = 0;
      if (rq.size() != 0 && rq[0].due == cyc) begin
        if (rq[0].disp) begin dv = 1; dd = rq[0].data; end
        else            begin sv = 1; sd = rq[0].data; end
        void'(rq.pop_front());
      end
      chk("disp_valid", 32'(disp_valid), 32'(dv));
      chk("sens_valid", 32'(sens_valid), 32'(sv));
      chk("disp_data", 32'(disp_data), 32'(dd));
      chk("sens_data", 32'(sens_data), 32'(sd));
      chk("busy", 32'(busy), 32'(e_busy));
      // a write granted last cycle has now reached the RAM
      if (pw_v) shadow[pw_a] = pw_d;
      pw_v = 0;
      if (disp_req && !(GUARD && starve >= SMAX)) win = W_DISP;
      else if (wr_req && sens_req)                win = turn;
      else if (wr_req)                            win = W_WR;
      else if (sens_req)                          win = W_SENS;
      else                                        win = W_NONE;
      chk("disp_gnt", 32'(disp_gnt), 32'(win == W_DISP));
      chk("sens_gnt", 32'(sens_gnt), 32'(win == W_SENS));
      chk("wr_gnt",   32'(wr_gnt),   32'(win == W_WR));
      e_miss = disp_req && (win != W_DISP);
      e_en = (win != W_NONE);
      e_we = (win == W_WR);
      if (win == W_WR || win == W_SENS) begin
        starve = 0;
        turn = (win == W_WR) ? W_SENS : W_WR;
      end else if (wr_req || sens_req) begin
        starve++;
      end
      case (win)
        W_DISP: begin e_addr = disp_addr; rq.push_back('{cyc + 2, 1'b1, shadow[disp_addr]}); end
        W_SENS: begin e_addr = sens_addr; rq.push_back('{cyc + 2, 1'b0, shadow[sens_addr]}); end
        W_WR:   begin e_addr = wr_addr; e_wdata = wr_data; pw_v = 1; pw_a = wr_addr; pw_d = wr_data; end
        default: ;
      endcase
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(); @(posedge clock_50); #1; endtask
  task automatic neg();  @(negedge clock_50);      endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram[i] = 4'(i * 7);
      shadow[i] = 4'(i * 7);
    end
    ram[45] = 4'b0011; shadow[45] = 4'b0011;
    #1 reset_flag = 1;
    neg();
    chk("reset_mem_en", 32'(mem_en), 32'd0);
    chk("reset_valid", 32'({disp_valid, sens_valid}), 32'd0);
    step(); step(); reset_flag = 0;

    // lone sensor read of addr 45
    step(); sens_req = 1; sens_addr = 45;
    neg(); chk("lone_gnt", 32'(sens_gnt), 32'd1);
    step(); sens_req = 0;
    neg(); chk("lone_mem", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b0, 9'd45}));
    step();
    neg(); chk("lone_valid", 32'(sens_valid), 32'd1);
    chk("lone_data", 32'(sens_data), 32'd3);
    step(); step();

    // reset pulsed while the read is in flight
    sens_req = 1; sens_addr = 45;
    neg(); chk("rmid_gnt", 32'(sens_gnt), 32'd1);
    step(); sens_req = 0; reset_flag = 1;
    neg(); chk("rmid_mem_en", 32'(mem_en), 32'd0);
    step();
    neg(); chk("rmid_no_valid", 32'(sens_valid), 32'd0);
    step(); reset_flag = 0; sens_req = 1;
    neg(); chk("rmid_first_gnt", 32'(sens_gnt), 32'd1);
    step(); sens_req = 0;
    step(); step();

    // display vs sensor
    disp_req = 1; disp_addr = 10; sens_req = 1; sens_addr = 20;
    for (int k = 0; k < 5; k++) begin
      neg();
      if (k < 3) chk("dvs_disp", 32'({disp_gnt, sens_gnt}), 32'b10);
      if (k == 3) chk("dvs_sens", 32'({disp_gnt, sens_gnt}), 32'b01);
      chk("dvs_miss", 32'(disp_miss), 32'd0);
      step();
      if (k == 2) disp_req = 0;
      if (k == 3) sens_req = 0;
    end
    step();

    // round-robin after reset: write 70 then read it back
    reset_flag = 1; step(); reset_flag = 0;
    wr_req = 1; wr_addr = 70; wr_data = 4'b0001; sens_req = 1; sens_addr = 70;
    neg(); chk("rr_wr_first", 32'({wr_gnt, sens_gnt}), 32'b10);
    step(); wr_req = 0;
    neg(); chk("rr_sens_next", 32'({wr_gnt, sens_gnt}), 32'b01);
    step(); sens_req = 0;
    step();
    neg(); chk("rr_valid", 32'(sens_valid), 32'd1);
    chk("rr_data", 32'(sens_data), 32'd1);
    step(); step();

    // starvation under continuous display traffic
    disp_req = 1; disp_addr = 0; sens_req = 1; sens_addr = 100;
    for (int k = 0; k < (GUARD ? 10 : 100); k++) begin
      neg();
      if (GUARD) begin
        chk("starve_gnt", 32'(sens_gnt), 32'(k == 8));
        if (k == 9) chk("starve_miss", 32'(disp_miss), 32'd1);
      end else begin
        chk("nostarve_gnt", 32'(sens_gnt), 32'd0);
        chk("nostarve_busy", 32'(busy), 32'd1);
      end
      step();
      disp_addr = 9'(k + 1);
      if (GUARD && k == 8) sens_req = 0;
    end
    disp_req = 0;
    step(); sens_req = 0;
    step(); step();

    // mixed traffic, checked by the model
    for (int k = 0; k < 300; k++) begin
      disp_req  = ($urandom_range(0, 2) == 0);
      disp_addr = 9'($urandom_range(0, 319));
      sens_req  = ($urandom_range(0, 1) == 0);
      sens_addr = 9'($urandom_range(0, 63));
      wr_req    = ($urandom_range(0, 2) == 0);
      wr_addr   = 9'($urandom_range(0, 63));
      wr_data   = 4'($urandom_range(0, 15));
      step();
    end
    disp_req = 0; sens_req = 0; wr_req = 0;
    repeat (4) step();
    neg();
    chk("idle_busy", 32'(busy), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
